// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers on the MEM-stage
// data bus, one-shot or auto-reload countdown, level interrupt to CP0.
module timer_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic [3:0]  WE,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } state_e;

    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

    state_e      state_q;
    logic [3:0]  ctrl_q;
    logic [3:0]  ctrl_d;
    logic [31:0] preset_q;
    logic [31:0] preset_d;
    logic [31:0] count_q;
    logic        irq_flag_q;

    logic [29:0] offset;
    logic        hit_ctrl, hit_preset, hit_count;
    logic        wr_ctrl, wr_preset;
    logic        enable, auto_reload, irq_mask;

    // Addresses below the base wrap to large offsets, so one compare covers both ends.
    assign offset     = Addr - BASE_WORD;
    assign hit_ctrl   = (offset == 30'd0);
    assign hit_preset = (offset == 30'd1);
    assign hit_count  = (offset == 30'd2);
    assign wr_ctrl    = hit_ctrl   && (WE != 4'b0000);
    assign wr_preset  = hit_preset && (WE != 4'b0000);

    assign enable      = ctrl_q[0];
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    assign irq_mask    = ctrl_q[3];

    // Byte-lane merge of bus data into the writable registers.
    always_comb begin
        ctrl_d   = WE[0] ? WData[3:0] : ctrl_q;
        preset_d = preset_q;
        for (int i = 0; i < 4; i++) begin
            if (WE[i]) preset_d[8*i +: 8] = WData[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= 4'h0;
            preset_q   <= 32'h0;
            count_q    <= 32'h0;
            irq_flag_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (enable) state_q <= LOAD;
                LOAD: begin
                    count_q <= preset_q;
                    state_q <= CNT;
                end
                CNT: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q    <= 32'h0;
                        irq_flag_q <= 1'b1;
                        state_q    <= INT;
                    end
                end
                INT: begin
                    if (auto_reload) irq_flag_q <= 1'b0;
                    else             ctrl_q[0]  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // NOTE: the bus updates come after the FSM so their non-blocking
            // assignments land last and win over FSM updates on the same edge.
            if (wr_ctrl) begin
                ctrl_q     <= ctrl_d;
                irq_flag_q <= 1'b0;
            end
            if (wr_preset) begin
                preset_q   <= preset_d;
                irq_flag_q <= 1'b0;
            end
        end
    end

    always_comb begin
        RData = 32'h0;
        if (hit_ctrl)        RData = {28'h0, ctrl_q};
        else if (hit_preset) RData = preset_q;
        else if (hit_count)  RData = count_q;
    end

    assign IRQ = irq_flag_q & irq_mask;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: expected values are queued as stimulus
// is applied and popped when the corresponding DUT output is sampled.
module tb_timer_dev;

    localparam logic [29:0] W_CTRL = 30'h0000_1FC0;
    localparam logic [29:0] W_PRE  = 30'h0000_1FC1;
    localparam logic [29:0] W_CNT  = 30'h0000_1FC2;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic [3:0]  WE;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        IRQ;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .WData (WData),
        .RData (RData),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [29:0] a, input logic [3:0] we, input logic [31:0] d);
        Addr  = a;
        WE    = we;
        WData = d;
        tick();
        WE    = 4'b0000;
        WData = 32'h0;
    endtask

    task automatic bus_read(input logic [29:0] a, output logic [31:0] d);
        Addr = a;
        WE   = 4'b0000;
        #1;
        d = RData;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [29:0] addrs[5];
        addrs = '{W_CTRL, W_PRE, W_CNT, 30'h0000_1FC3, 30'h0000_1FBF};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(32'h0);
            bus_read(addrs[i], v);
            checks++;
            if (v !== exp_q.pop_front()) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h expected 00000000", i, v);
            end
        end
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", IRQ);
        end
        bus_write(30'h0000_1FC3, 4'hF, 32'hFFFF_FFFF);
        bus_write(30'h0000_1FBF, 4'hF, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h0);
            bus_read(addrs[i], v);
            checks++;
            if (v !== exp_q.pop_front()) begin
                errors++;
                $display("FAIL outside_write[%0d]: got %h expected 00000000", i, v);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        do_reset();
        bus_write(W_PRE, 4'hF, 32'd3);
        bus_write(W_CTRL, 4'hF, 32'h9);   // edge E0
        tick();                           // E0+1: LOAD
        for (int k = 0; k < 4; k++) exp_q.push_back(32'd3 - k);
        for (int k = 0; k < 4; k++) begin
            tick();                       // E0+2+k
            bus_read(W_CNT, v);
            checks++;
            if (v !== exp_q.pop_front()) begin
                errors++;
                $display("FAIL oneshot_count[%0d]: got %0d expected %0d", k, v, 3 - k);
            end
            checks++;
            if (IRQ !== (k == 3)) begin
                errors++;
                $display("FAIL oneshot_irq[%0d]: got %b expected %b", k, IRQ, k == 3);
            end
        end
        tick();                           // E0+6
        bus_read(W_CTRL, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL oneshot_ctrl: got %h expected 00000008", v);
        end
        repeat (3) tick();
        checks++;
        if (IRQ !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_irq_hold: got %b expected 1", IRQ);
        end
        bus_write(W_CTRL, 4'hF, 32'h8);
        checks++;
        if (IRQ !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_clear: got %b expected 0", IRQ);
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        int pulses = 0;
        bit saw_two = 0, saw_zero = 0;
        do_reset();
        bus_write(W_PRE, 4'hF, 32'd2);
        bus_write(W_CTRL, 4'hF, 32'hB);   // edge E0
        for (int t = 1; t <= 20; t++)
            exp_q.push_back({31'h0, (t >= 4) && ((t - 4) % 5 == 0)});
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (IRQ === 1'b1) pulses++;
            checks++;
            if ({31'h0, IRQ} !== exp_q[0]) begin
                errors++;
                $display("FAIL auto_irq[t=%0d]: got %b expected %b", t, IRQ, exp_q[0][0]);
            end
            void'(exp_q.pop_front());
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL auto_pulse_count: got %0d expected 4", pulses);
        end
        bus_write(W_CTRL, 4'hF, 32'h3);
        for (int t = 0; t < 15; t++) begin
            tick();
            bus_read(W_CNT, v);
            if (v == 32'd2) saw_two = 1;
            if (v == 32'd0) saw_zero = 1;
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("FAIL auto_masked_irq[t=%0d]: got %b expected 0", t, IRQ);
            end
        end
        checks++;
        if (!(saw_two && saw_zero)) begin
            errors++;
            $display("FAIL auto_masked_cycling: saw2=%0b saw0=%0b expected 1 1", saw_two, saw_zero);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] v;
        do_reset();
        bus_write(W_PRE, 4'hF, 32'h1122_3344);
        bus_write(W_PRE, 4'b0010, 32'h0000_AB00);
        exp_q.push_back(32'h1122_AB44);
        bus_read(W_PRE, v);
        checks++;
        if (v !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL byte_write_preset: got %h expected 1122ab44", v);
        end
        bus_write(W_CNT, 4'hF, 32'h0000_FFFF);
        exp_q.push_back(32'h0);
        bus_read(W_CNT, v);
        checks++;
        if (v !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL count_readonly: got %h expected 00000000", v);
        end
        bus_write(W_CTRL, 4'b0010, 32'h0000_FF00);
        bus_read(W_CTRL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL ctrl_upper_lane: got %h expected 00000000", v);
        end
    endtask

    task automatic test_disable_freeze();
        logic [31:0] v;
        do_reset();
        bus_write(W_PRE, 4'hF, 32'd10);
        bus_write(W_CTRL, 4'hF, 32'h9);   // edge E0
        repeat (5) tick();                // E0+5: COUNT = 7
        bus_read(W_CNT, v);
        checks++;
        if (v !== 32'd7) begin
            errors++;
            $display("FAIL freeze_pre: got %0d expected 7", v);
        end
        bus_write(W_CTRL, 4'hF, 32'h0);   // COUNT reaches 6 on this edge
        for (int t = 0; t < 5; t++) begin
            exp_q.push_back(32'd6);
            bus_read(W_CNT, v);
            checks++;
            if (v !== exp_q.pop_front() || IRQ !== 1'b0) begin
                errors++;
                $display("FAIL freeze_hold[%0d]: got count=%0d irq=%b expected count=6 irq=0", t, v, IRQ);
            end
            tick();
        end
        bus_write(W_CTRL, 4'hF, 32'h9);   // edge E1
        tick();                           // E1+1: LOAD
        tick();                           // E1+2: reloaded
        bus_read(W_CNT, v);
        checks++;
        if (v !== 32'd10) begin
            errors++;
            $display("FAIL freeze_reload: got %0d expected 10", v);
        end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] v;
        logic [29:0] addrs[3];
        addrs = '{W_CTRL, W_PRE, W_CNT};
        do_reset();
        bus_write(W_PRE, 4'hF, 32'd10);
        bus_write(W_CTRL, 4'hF, 32'hB);   // edge E0
        repeat (8) tick();                // E0+8: COUNT = 4
        bus_read(W_CNT, v);
        checks++;
        if (v !== 32'd4) begin
            errors++;
            $display("FAIL midreset_pre: got %0d expected 4", v);
        end
        do_reset();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 3; i++) begin
                exp_q.push_back(32'h0);
                bus_read(addrs[i], v);
                checks++;
                if (v !== exp_q.pop_front()) begin
                    errors++;
                    $display("FAIL midreset_reg[t=%0d,%0d]: got %h expected 00000000", t, i, v);
                end
            end
            checks++;
            if (IRQ !== 1'b0) begin
                errors++;
                $display("FAIL midreset_irq[t=%0d]: got %b expected 0", t, IRQ);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        Addr  = '0;
        WE    = 4'b0000;
        WData = 32'h0;
        tick();
        test_reset();
        test_oneshot();
        test_autoreload();
        test_byte_write();
        test_disable_freeze();
        test_reset_midcount();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
